// File: rtl/demux_buf_if.sv
// demux_buf_if: bundles the producer-side and the two consumer-side handshakes of demux_buf.
//   Producer side: in_data, s (0 -> channel a, 1 -> channel b), in_valid, in_ready.
//   Channel a/b:   x_data (head word), x_valid, x_ready, x_cnt (words accepted since reset).
// The slave modport is the buffer's view. The master modport is the view of the
// producer/consumers that surround it.
interface demux_buf_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [CNT_W-1:0] a_cnt;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] b_cnt;

  modport slave (
    input  in_data, s, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, a_cnt, b_data, b_valid, b_cnt
  );

  modport master (
    output in_data, s, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, a_cnt, b_data, b_valid, b_cnt
  );
endinterface

// File: rtl/demux_buf.sv
// demux_buf: routes each accepted input word into one of two 2-entry FIFOs.
// The select s chooses the FIFO: 0 -> channel a, 1 -> channel b.
// Each channel also keeps a wrapping count of the words it has accepted.
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high; clears all storage, occupancies and counts
//   bus  - demux_buf_if.slave (producer handshake plus channel a/b handshakes and counts)
// Index 0 is channel a and index 1 is channel b.
// Entry 0 of a channel is always its head. A pop shifts entry 1 down only when
// two words are stored. When the last word leaves, entry 0 keeps the popped value.
module demux_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  demux_buf_if.slave   bus
);

  logic [1:0]       occ_q [2];
  logic [1:0]       occ_d [2];
  logic [WIDTH-1:0] e0_q  [2];
  logic [WIDTH-1:0] e0_d  [2];
  logic [WIDTH-1:0] e1_q  [2];
  logic [WIDTH-1:0] e1_d  [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic             in_ready;
  logic             push;
  logic [1:0]       sel_occ;
  logic [1:0]       rdy;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    sel_occ  = bus.s ? occ_q[1] : occ_q[0];
    // Readiness depends only on the selected channel's occupancy, never on the consumer.
    in_ready = ~rst & (sel_occ != 2'd2);
    push     = bus.in_valid & in_ready;
    rdy[0]   = bus.a_ready;
    rdy[1]   = bus.b_ready;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      occ_d[c] = occ_q[c];
      e0_d[c]  = e0_q[c];
      e1_d[c]  = e1_q[c];
      do_push  = push & (bus.s == 1'(c));
      do_pop   = (occ_q[c] != 2'd0) & rdy[c];
      cnt_d[c] = cnt_q[c] + CNT_W'(do_push);
      case (occ_q[c])
        2'd0: begin
          if (do_push) begin
            e0_d[c]  = bus.in_data;
            occ_d[c] = 2'd1;
          end
        end
        2'd1: begin
          if (do_push && do_pop) begin
            e0_d[c] = bus.in_data;
          end else if (do_push) begin
            e1_d[c]  = bus.in_data;
            occ_d[c] = 2'd2;
          end else if (do_pop) begin
            occ_d[c] = 2'd0;
          end
        end
        default: begin
          // A full channel never accepts a push, so only a pop can happen here.
          if (do_pop) begin
            e0_d[c]  = e1_q[c];
            occ_d[c] = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        occ_q[c] <= 2'd0;
        e0_q[c]  <= '0;
        e1_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        occ_q[c] <= occ_d[c];
        e0_q[c]  <= e0_d[c];
        e1_q[c]  <= e1_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.a_data   = e0_q[0];
  assign bus.a_valid  = (occ_q[0] != 2'd0);
  assign bus.a_cnt    = cnt_q[0];
  assign bus.b_data   = e0_q[1];
  assign bus.b_valid  = (occ_q[1] != 2'd0);
  assign bus.b_cnt    = cnt_q[1];

endmodule
